// File: rtl/kgp_branch_pkg.sv
// kgp_branch_pkg: shared opcodes, FSM states and flag bit positions for branch resolution
package kgp_branch_pkg;
  localparam logic [2:0] B    = 3'd0;
  localparam logic [2:0] BR   = 3'd1;
  localparam logic [2:0] BLTZ = 3'd2;
  localparam logic [2:0] BZ   = 3'd3;
  localparam logic [2:0] BNZ  = 3'd4;
  localparam logic [2:0] BL   = 3'd5;
  localparam logic [2:0] BCY  = 3'd6;
  localparam logic [2:0] BNCY = 3'd7;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
endpackage

// File: rtl/flag_register.sv
// flag_register: architectural ALU flag latch with same-cycle carry forwarding
module flag_register import kgp_branch_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       carry_in,
  input  logic       zero_in,
  input  logic       neg_in,
  input  logic       ovf_in,
  output logic [3:0] flags,
  output logic       carry_fwd
);
  assign carry_fwd = flag_we ? carry_in : flags[FLAG_C];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags <= '0;
    else if (flag_we) flags <= {carry_in, zero_in, neg_in, ovf_in};
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: two-cycle KGP-RISC branch evaluation with flag register and link address
module branch_resolver import kgp_branch_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              neg_in,
  input  logic              ovf_in,
  output logic [3:0]        flags_out,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_src,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  output logic              resolve_valid,
  output logic              taken,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              link_en,
  output logic [ADDR_W-1:0] link_addr
);
  state_t state, state_d;
  logic [2:0] op_q;
  logic [ADDR_W-1:0] src_q, pc_q, off_q, tgt, seq;
  logic cy_q, carry_fwd, cond, accept;
  flag_register u_flags (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .carry_in(carry_in), .zero_in(zero_in),
    .neg_in(neg_in), .ovf_in(ovf_in), .flags(flags_out), .carry_fwd(carry_fwd)
  );
  assign br_ready = state == IDLE;
  assign accept = br_valid && br_ready;
  assign seq = pc_q + ADDR_W'(4);
  assign tgt = op_q == BR ? src_q : pc_q + off_q;
  always_comb begin
    cond = 1'b1;
    case (op_q)
      BLTZ:    cond = src_q[ADDR_W-1];
      BZ:      cond = src_q == '0;
      BNZ:     cond = src_q != '0;
      BCY:     cond = cy_q;
      BNCY:    cond = !cy_q;
      default: cond = 1'b1;
    endcase
  end
  always_comb state_d = state == IDLE ? (accept ? EVAL : IDLE) : state == EVAL ? DONE : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      src_q <= '0;
      pc_q <= '0;
      off_q <= '0;
      cy_q <= 1'b0;
      resolve_valid <= 1'b0;
      taken <= 1'b0;
      redirect_pc <= '0;
      link_en <= 1'b0;
      link_addr <= '0;
    end else begin
      if (accept) begin
        op_q <= br_op;
        src_q <= br_src;
        pc_q <= pc;
        off_q <= offset;
        cy_q <= carry_fwd;
      end
      resolve_valid <= state == EVAL;
      if (state == EVAL) begin
        taken <= cond;
        redirect_pc <= cond ? tgt : seq;
        link_en <= op_q == BL;
        link_addr <= seq;
      end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with a queue scoreboard checked by an independent monitor
module tb_branch_resolver;
  import kgp_branch_pkg::*;
  typedef struct {
    logic        t;
    logic [31:0] r;
    logic        l;
    logic [31:0] la;
    int          acc;
  } exp_t;
  logic clk = 0, rst_n = 0, flag_we = 0, carry_in = 0, zero_in = 0, neg_in = 0, ovf_in = 0;
  logic br_valid = 0, br_ready, resolve_valid, taken, link_en;
  logic [2:0] br_op = 0;
  logic [31:0] br_src = 0, pc = 0, offset = 0, redirect_pc, link_addr;
  logic [3:0] flags_out;
  exp_t q[$];
  int cyc = 0, cmp = 0, errs = 0, last_acc = 0, prev_acc = 0;
  branch_resolver #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .carry_in(carry_in), .zero_in(zero_in),
    .neg_in(neg_in), .ovf_in(ovf_in), .flags_out(flags_out), .br_valid(br_valid),
    .br_ready(br_ready), .br_op(br_op), .br_src(br_src), .pc(pc), .offset(offset),
    .resolve_valid(resolve_valid), .taken(taken), .redirect_pc(redirect_pc),
    .link_en(link_en), .link_addr(link_addr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (resolve_valid) begin
      if (q.size() == 0) chk("spurious_resolve", 32'(resolve_valid), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 32'(cyc), 32'(e.acc + 2));
        chk("taken", 32'(taken), 32'(e.t));
        chk("redirect_pc", redirect_pc, e.r);
        chk("link_en", 32'(link_en), 32'(e.l));
        chk("link_addr", link_addr, e.la);
      end
    end
  task automatic send(input logic [2:0] op, input logic [31:0] src, p, off, input logic et,
                      input logic [31:0] er, input logic el, input bit push, input logic fwe, fc);
    int n = 0;
    @(negedge clk);
    br_op = op; br_src = src; pc = p; offset = off; br_valid = 1; flag_we = fwe; carry_in = fc;
    while (!br_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(br_ready), 32'd1);
    prev_acc = last_acc;
    last_acc = cyc;
    if (push) q.push_back('{et, er, el, p + 32'd4, cyc});
    @(posedge clk);
    #1 flag_we = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    br_valid = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask
  task automatic set_flags(input logic [3:0] f);
    @(negedge clk);
    flag_we = 1; {carry_in, zero_in, neg_in, ovf_in} = f;
    @(negedge clk);
    flag_we = 0; {carry_in, zero_in, neg_in, ovf_in} = 4'h0;
    chk("flags_load", 32'(flags_out), 32'(f));
  endtask
  initial begin
    logic [31:0] srcs [3];
    logic [2:0] cops [3];
    logic [2:0] tk [3];
    logic b;
    srcs = '{32'h0, 32'h5, 32'h80000000};
    cops = '{BZ, BNZ, BLTZ};
    tk = '{3'b100, 3'b010, 3'b011};
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(br_ready), 32'd1);
    chk("rst_valid", 32'(resolve_valid), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_link", {link_addr[30:0], link_en}, 32'd0);
    rst_n = 1;
    send(BL, 32'h0, 32'h100, 32'h40, 1, 32'h140, 1, 1, 0, 0);
    br_valid = 0;
    @(negedge clk) chk("ready_eval", 32'(br_ready), 32'd0);
    @(negedge clk) chk("ready_done", 32'(br_ready), 32'd0);
    @(negedge clk) chk("ready_back", 32'(br_ready), 32'd1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        b = tk[i][2-j];
        send(cops[j], srcs[i], 32'h200, 32'h10, b, b ? 32'h210 : 32'h204, 0, 1, 0, 0);
      end
    wait_idle();
    send(BCY, 32'h0, 32'h300, 32'h8, 1, 32'h308, 0, 1, 1, 1);
    wait_idle();
    chk("fwd_carry_latched", 32'(flags_out[FLAG_C]), 32'd1);
    send(BNCY, 32'h0, 32'h400, 32'h100, 0, 32'h404, 0, 1, 0, 0);
    br_valid = 0; flag_we = 1; carry_in = 0;
    @(posedge clk);
    #1 flag_we = 0;
    wait_idle();
    chk("carry_after_eval_write", 32'(flags_out[FLAG_C]), 32'd0);
    send(BNCY, 32'h0, 32'h600, 32'h20, 1, 32'h620, 0, 1, 0, 0);
    send(B, 32'h0, 32'hFFFFFFF0, 32'h20, 1, 32'h10, 0, 1, 0, 0);
    wait_idle();
    set_flags(4'hF);
    send(BR, 32'hDEAD0000, 32'h500, 32'h0, 1, 32'hDEAD0000, 0, 0, 0, 0);
    br_valid = 0;
    rst_n = 0;
    #2;
    chk("rst_eval_valid", 32'(resolve_valid), 32'd0);
    chk("rst_eval_flags", 32'(flags_out), 32'd0);
    chk("rst_eval_ready", 32'(br_ready), 32'd1);
    @(negedge clk) chk("rst_hold_valid", 32'(resolve_valid), 32'd0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    send(BR, 32'hDEAD0000, 32'h500, 32'h0, 1, 32'hDEAD0000, 0, 1, 0, 0);
    wait_idle();
    send(BR, 32'h1000, 32'h700, 32'h4, 1, 32'h1000, 0, 1, 0, 0);
    send(BR, 32'h2000, 32'h710, 32'h4, 1, 32'h2000, 0, 1, 0, 0);
    chk("b2b_gap1", 32'(last_acc - prev_acc), 32'd3);
    send(BR, 32'h3000, 32'h720, 32'h4, 1, 32'h3000, 0, 1, 0, 0);
    chk("b2b_gap2", 32'(last_acc - prev_acc), 32'd3);
    wait_idle();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
